// File: rtl/ahb_timer.sv
// AHB-Lite down-counting timer with prescaler and sticky interrupt.
// Zero-wait-state slave: LOAD, VALUE, CONTROL and CLEAR registers.
module ahb_timer #(
    parameter logic [31:0] RESET_LOAD     = 32'h0000_0000,
    parameter int          PRESC_16_BITS  = 4,
    parameter int          PRESC_256_BITS = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        timer_irq
);

    localparam logic [1:0] A_LOAD  = 2'b00;
    localparam logic [1:0] A_VALUE = 2'b01;
    localparam logic [1:0] A_CTRL  = 2'b10;
    localparam logic [1:0] A_CLEAR = 2'b11;

    logic                      a_valid;
    logic                      a_write;
    logic [1:0]                a_addr;
    logic [31:0]               load_q;
    logic [31:0]               value_q;
    logic [3:0]                ctrl_q;
    logic                      irq_q;
    logic [PRESC_256_BITS-1:0] presc_cnt;

    logic en;
    logic mode;
    logic tick;
    logic timeout;
    logic wr_en;
    logic load_wr;
    logic ctrl_wr;
    logic clr_wr;

    // Address bits below word granularity, upper address and size are unused.
    logic unused_bits;
    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign timer_irq = irq_q;

    assign en      = ctrl_q[0];
    assign mode    = ctrl_q[1];
    assign wr_en   = a_valid & a_write;
    assign load_wr = wr_en & (a_addr == A_LOAD);
    assign ctrl_wr = wr_en & (a_addr == A_CTRL);
    assign clr_wr  = wr_en & (a_addr == A_CLEAR);
    assign timeout = en & tick & (value_q == 32'h0);

    // Capture the address phase; the data phase uses these next cycle.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            a_valid <= 1'b0;
            a_write <= 1'b0;
            a_addr  <= 2'b00;
        end else begin
            a_valid <= HSEL & HREADY & HTRANS[1];
            a_write <= HWRITE;
            a_addr  <= HADDR[3:2];
        end
    end

    // Prescale counter runs only while enabled and restarts on CONTROL writes.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            presc_cnt <= '0;
        end else if (!en || ctrl_wr) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Tick select: /16 and /256 fire when their counter slice is all ones.
    always_comb begin
        tick = 1'b1;
        unique case (ctrl_q[3:2])
            2'b01:   tick = &presc_cnt[PRESC_16_BITS-1:0];
            2'b10:   tick = &presc_cnt;
            default: tick = 1'b1;
        endcase
    end

    // LOAD/VALUE: a LOAD write overrides any decrement or reload on that edge.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            load_q  <= RESET_LOAD;
            value_q <= RESET_LOAD;
        end else if (load_wr) begin
            load_q  <= HWDATA;
            value_q <= HWDATA;
        end else if (en && tick) begin
            if (value_q != 32'h0) begin
                value_q <= value_q - 32'h1;
            end else if (mode) begin
                value_q <= load_q;
            end else begin
                value_q <= 32'hFFFF_FFFF;
            end
        end
    end

    // CONTROL register keeps only EN, MODE and PRESC.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ctrl_q <= 4'h0;
        end else if (ctrl_wr) begin
            ctrl_q <= HWDATA[3:0];
        end
    end

    // Sticky interrupt; a timeout beats a CLEAR on the same edge.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            irq_q <= 1'b0;
        end else if (timeout) begin
            irq_q <= 1'b1;
        end else if (clr_wr) begin
            irq_q <= 1'b0;
        end
    end

    // Read data from the registered address; zero unless a read is in flight.
    always_comb begin
        HRDATA = 32'h0;
        if (a_valid && !a_write) begin
            case (a_addr)
                A_LOAD:  HRDATA = load_q;
                A_VALUE: HRDATA = value_q;
                A_CTRL:  HRDATA = {28'h0, ctrl_q};
                A_CLEAR: HRDATA = 32'h0;
                default: HRDATA = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_timer.sv
// Directed bench for ahb_timer: per-cycle vector table for the bus
// pipeline plus sequences for prescaler, reset and back-to-back cases.
module tb_ahb_timer;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    ahb_timer dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .timer_irq (timer_irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // One cycle of bus activity: address phase fields plus HWDATA for the
    // previous write; rd/irq are expected just after the edge.
    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        rdy;
        logic        wr;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic sel, input logic [1:0] trans,
                       input logic rdy, input logic wr, input logic [1:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input logic irq);
        vec_t v;
        v.sel = sel; v.trans = trans; v.rdy = rdy; v.wr = wr;
        v.a = a; v.wd = wd; v.rd = rd; v.irq = irq;
        tbl.push_back(v);
    endtask

    task automatic rv(input logic [1:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input logic irq);
        add(1'b1, 2'b10, 1'b1, 1'b0, a, wd, rd, irq);
    endtask

    task automatic wv(input logic [1:0] a, input logic [31:0] wd,
                      input logic irq);
        add(1'b1, 2'b10, 1'b1, 1'b1, a, wd, 32'h0, irq);
    endtask

    task automatic idle_bus();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HREADY = 1'b1;
        HADDR  = 32'h0;
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HREADY = 1'b1;
        HADDR = {28'h0, a, 2'b00};
        step();
        idle_bus();
        HWDATA = d;
        step();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HREADY = 1'b1;
        HADDR = {28'h0, a, 2'b00};
        step();
        d = HRDATA;
        idle_bus();
    endtask

    task automatic wait_irq(input int max, output int n);
        n = 0;
        while (!timer_irq && n < max) begin
            step();
            n++;
        end
        check("irq_within_bound", {31'h0, timer_irq}, 32'h1);
    endtask

    logic [31:0] d;
    int          n;

    initial begin
        HRESETn = 1'b0;
        HSIZE   = 3'b010;
        HWDATA  = 32'h0;
        idle_bus();

        // Table, starting straight after reset.
        rv(2'd0, 32'h0, 32'h0, 1'b0);
        rv(2'd1, 32'h0, 32'h0, 1'b0);
        rv(2'd2, 32'h0, 32'h0, 1'b0);
        rv(2'd3, 32'h0, 32'h0, 1'b0);
        add(1'b1, 2'b00, 1'b1, 1'b0, 2'd1, 32'h0, 32'h0, 1'b0);
        // Periodic /1, LOAD=4.
        wv(2'd0, 32'h0, 1'b0);
        wv(2'd2, 32'h4, 1'b0);
        rv(2'd1, 32'h3, 32'h4, 1'b0);
        rv(2'd1, 32'h0, 32'h3, 1'b0);
        rv(2'd1, 32'h0, 32'h2, 1'b0);
        rv(2'd1, 32'h0, 32'h1, 1'b0);
        rv(2'd1, 32'h0, 32'h0, 1'b0);
        rv(2'd1, 32'h0, 32'h4, 1'b1);
        rv(2'd1, 32'h0, 32'h3, 1'b1);
        // CLEAR, then CLEAR on the timeout edge.
        wv(2'd3, 32'h0, 1'b1);
        rv(2'd1, 32'h0, 32'h1, 1'b0);
        wv(2'd3, 32'h0, 1'b0);
        rv(2'd1, 32'h0, 32'h4, 1'b1);
        // LOAD on a tick edge, overlapped with a VALUE read.
        wv(2'd0, 32'h0, 1'b1);
        rv(2'd1, 32'd10, 32'd10, 1'b1);
        rv(2'd0, 32'h0, 32'd10, 1'b1);
        rv(2'd1, 32'h0, 32'd8, 1'b1);
        rv(2'd2, 32'h0, 32'h3, 1'b1);
        // Disable and clear: VALUE freezes.
        wv(2'd2, 32'h0, 1'b1);
        wv(2'd3, 32'h0, 1'b1);
        rv(2'd1, 32'h0, 32'h5, 1'b0);
        rv(2'd1, 32'h0, 32'h5, 1'b0);
        // Free-run from LOAD=1.
        wv(2'd0, 32'h0, 1'b0);
        wv(2'd2, 32'h1, 1'b0);
        rv(2'd1, 32'h1, 32'h1, 1'b0);
        rv(2'd1, 32'h0, 32'h0, 1'b0);
        rv(2'd1, 32'h0, 32'hFFFF_FFFF, 1'b1);
        rv(2'd1, 32'h0, 32'hFFFF_FFFE, 1'b1);
        rv(2'd2, 32'h0, 32'h1, 1'b1);
        // VALUE is read-only.
        wv(2'd1, 32'h0, 1'b1);
        rv(2'd1, 32'h1234, 32'hFFFF_FFFB, 1'b1);
        // CONTROL upper bits read 0; PRESC=11 counts as /1.
        wv(2'd2, 32'h0, 1'b1);
        rv(2'd2, 32'hABCD_E00C, 32'hC, 1'b1);
        rv(2'd1, 32'h0, 32'hFFFF_FFF9, 1'b1);
        wv(2'd2, 32'h0, 1'b1);
        rv(2'd1, 32'hD, 32'hFFFF_FFF9, 1'b1);
        rv(2'd1, 32'h0, 32'hFFFF_FFF8, 1'b1);
        rv(2'd1, 32'h0, 32'hFFFF_FFF7, 1'b1);
        wv(2'd2, 32'h0, 1'b1);
        add(1'b0, 2'b10, 1'b1, 1'b0, 2'd1, 32'h0, 32'h0, 1'b1);
        rv(2'd1, 32'h0, 32'hFFFF_FFF5, 1'b1);
        // HREADY low: no transfer, HRDATA 0.
        add(1'b1, 2'b10, 1'b0, 1'b0, 2'd1, 32'h0, 32'h0, 1'b1);

        // Reset for two cycles.
        step();
        step();
        HRESETn = 1'b1;
        check("reset_irq", {31'h0, timer_irq}, 32'h0);
        check("reset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("reset_hresp", {31'h0, HRESP}, 32'h0);
        check("reset_hrdata_idle", HRDATA, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            HSEL   = tbl[i].sel;
            HTRANS = tbl[i].trans;
            HREADY = tbl[i].rdy;
            HWRITE = tbl[i].wr;
            HADDR  = {28'h0, tbl[i].a, 2'b00};
            HWDATA = tbl[i].wd;
            step();
            check($sformatf("vec%0d_hrdata", i), HRDATA, tbl[i].rd);
            check($sformatf("vec%0d_irq", i), {31'h0, timer_irq},
                  {31'h0, tbl[i].irq});
            check($sformatf("vec%0d_okay", i), {30'h0, HREADYOUT, HRESP},
                  32'h2);
        end
        idle_bus();

        // Prescale /16, LOAD=2: timeout 48 cycles after enable.
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'h0);
        check("p16_clear", {31'h0, timer_irq}, 32'h0);
        bus_write(2'd0, 32'h2);
        bus_write(2'd2, 32'h7);
        wait_irq(200, n);
        check("p16_cycles", n, 32'd48);
        bus_read(2'd1, d);
        check("p16_reload", d, 32'h2);

        // Prescale /256, periodic LOAD=0: timeout every tick.
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'h0);
        check("p256_clear", {31'h0, timer_irq}, 32'h0);
        bus_write(2'd0, 32'h0);
        bus_write(2'd2, 32'hB);
        wait_irq(600, n);
        check("p256_cycles", n, 32'd256);

        // Reset mid-count and mid-transfer.
        bus_write(2'd0, 32'h7);
        bus_read(2'd1, d);
        check("mid_value", d, 32'h7);
        check("mid_irq", {31'h0, timer_irq}, 32'h1);
        HRESETn = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
        HADDR = 32'h0;
        step();
        HRESETn = 1'b1;
        idle_bus();
        HWDATA = 32'h5555_5555;
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        step();
        bus_read(2'd0, d);
        check("rst_load", d, 32'h0);
        bus_read(2'd1, d);
        check("rst_value", d, 32'h0);
        bus_read(2'd2, d);
        check("rst_ctrl", d, 32'h0);
        check("rst_irq_later", {31'h0, timer_irq}, 32'h0);

        // Back-to-back write LOAD then read VALUE.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
        HADDR = 32'h0;
        step();
        HWDATA = 32'h1234_5678;
        HWRITE = 1'b0;
        HADDR  = 32'h4;
        step();
        check("b2b_value", HRDATA, 32'h1234_5678);
        idle_bus();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_timer.md
Name: ahb_timer

Overview:
- AHB-Lite slave down-counting timer peripheral inside AHBLITE_SYS.
- Sits on the interconnect alongside the LED GPIO slave.
- Its timeout interrupt drives the Cortex-M0 IRQ that firmware uses to pace LED updates.
- Provides a load register, current value, control (enable / mode / prescale) and an interrupt clear register.

Parameters:
- RESET_LOAD, 32'h0000_0000, reset value of LOAD and VALUE registers.
- PRESC_16_BITS, 4, prescale counter width used for the /16 setting.
- PRESC_256_BITS, 8, prescale counter width used for the /256 setting.

Ports:
- HCLK  input  1  system clock; all state on rising edge.
- HRESETn  input  1  synchronous active-low reset.
- HSEL  input  1  slave select.
- HADDR  input  32  address; only [3:2] decoded.
- HTRANS  input  2  transfer type; bit1 set = NONSEQ/SEQ valid.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  ignored; word accesses only.
- HWDATA  input  32  write data (data phase).
- HREADY  input  1  bus ready; address phase sampled only when high.
- HREADYOUT  output  1  always 1 (zero wait state).
- HRESP  output  1  always 0 (OKAY).
- HRDATA  output  32  read data.
- timer_irq  output  1  level interrupt to NVIC.

Behaviour:
- Register map (HADDR[3:2]):
  - 00 = LOAD (RW).
  - 01 = VALUE (RO; writes ignored).
  - 10 = CONTROL (RW): bit0 EN, bit1 MODE (0 free-run, 1 periodic), bits[3:2] PRESC (00 /1, 01 /16, 10 /256, 11 treated as /1); bits[31:4] read 0.
  - 11 = CLEAR (WO; any write clears irq; reads 0).
- Address phase: when HSEL & HREADY & HTRANS[1], register HADDR[3:2], HWRITE and a valid flag. Otherwise valid = 0.
- Data phase:
  - Write commits at the end of the data phase using HWDATA.
  - Read: HRDATA is combinational from the registered address and current register contents.
  - HRDATA = 0 when no read is valid.
- Reset (HRESETn=0 at a clock edge):
  - LOAD = VALUE = RESET_LOAD; CONTROL = 0; prescale count = 0; timer_irq = 0; phase regs cleared.
  - HREADYOUT = 1 and HRESP = 0 at all times.
  - Reset asserted mid-count or mid-transfer aborts everything on that edge.
- Prescaler:
  - Counts HCLK cycles only while EN = 1.
  - tick = 1 every cycle for /1, every 16th cycle for /16, every 256th for /256.
  - Counter is cleared when EN = 0 or on a CONTROL write.
- Counting, on tick with EN = 1:
  - VALUE != 0: VALUE - 1.
  - VALUE == 0: timer_irq set to 1. VALUE becomes LOAD in periodic mode, 32'hFFFF_FFFF in free-run mode (wrap).
- Write to LOAD sets LOAD and VALUE to HWDATA on the same edge. This wins over a simultaneous tick.
- Periodic with LOAD = N: irq every N+1 ticks. LOAD = 0 with EN = 1: irq on every tick.
- timer_irq is sticky until a CLEAR write. If CLEAR and a timeout occur on the same edge, set wins (irq stays 1).
- EN = 0 freezes VALUE; irq is unaffected.
- Back-to-back transfers: the address phase of transfer N+1 overlaps the data phase of N and must not corrupt it.

Test Plan:
- Reset: drive HRESETn = 0 for 2 cycles, release → HRDATA reads LOAD = 0, VALUE = 0, CONTROL = 0; timer_irq = 0; HREADYOUT = 1.
- Periodic /1: write LOAD = 4, CONTROL = 3'b011 → VALUE reads 4,3,2,1,0,4 on successive cycles. timer_irq rises on the cycle VALUE reloads to 4 and stays high. Write CLEAR → irq = 0 next cycle.
- Free-run: LOAD = 1, CONTROL = 1 → VALUE sequence 1,0,FFFF_FFFF,FFFF_FFFE; irq set at the wrap.
- Prescale /16: LOAD = 2, CONTROL = 4'b0111 → VALUE decrements once per 16 HCLK; irq after 48 cycles from enable.
- Collisions:
  - CLEAR written on the exact timeout edge → irq remains 1.
  - LOAD = 10 written on a tick edge → VALUE = 10, not decremented.
- Reset mid-count (VALUE = 7, irq = 1) → next cycle all registers at reset values. Back-to-back write LOAD / read VALUE → read returns the new LOAD value.
